tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_pkg.sv | 31 +++
 rtl/tmds_symbol_decode.sv | 40 ++++
 rtl/tmds_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_tmds_decoder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states and offset width.
package tmds_pkg;

  localparam int                  OFFSET_W   = 4;
  localparam logic [OFFSET_W-1:0] OFFSET_MAX = 4'd9;

  localparam logic [9:0] TOKEN_C00 = 10'b1101010100;
  localparam logic [9:0] TOKEN_C01 = 10'b0010101011;
  localparam logic [9:0] TOKEN_C10 = 10'b0101010100;
  localparam logic [9:0] TOKEN_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_t;

  // Undo the optional inversion (bit9), then the XOR/XNOR chain selected by bit8.
  function automatic logic [7:0] tmds_data_decode(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d    = 8'h00;
    d[0] = q[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
    return d;
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational 10b symbol classifier: control token detection plus 10b->8b data decode.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] i_sym,
  output logic       o_is_token,
  output logic [1:0] o_ctrl,
  output logic [7:0] o_data
);

  // Token match; the data path is always computed and ignored by the caller on tokens.
  always_comb begin
    o_is_token = 1'b0;
    o_ctrl     = 2'b00;
    o_data     = tmds_data_decode(i_sym);
    case (i_sym)
      TOKEN_C00: begin
        o_is_token = 1'b1;
        o_ctrl     = 2'b00;
      end
      TOKEN_C01: begin
        o_is_token = 1'b1;
        o_ctrl     = 2'b01;
      end
      TOKEN_C10: begin
        o_is_token = 1'b1;
        o_ctrl     = 2'b10;
      end
      TOKEN_C11: begin
        o_is_token = 1'b1;
        o_ctrl     = 2'b11;
      end
      default: begin
        o_is_token = 1'b0;
        o_ctrl     = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with bit-slip word alignment (SEARCH/VERIFY/LOCKED).
// Optional statistics outputs are enabled by defining TMDS_DECODER_STATS_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN     = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [9:0]          tmds_in,
  output logic [7:0]          data_out,
  output logic [1:0]          control_out,
  output logic                ve_out,
  output logic                locked_out,
  output logic [OFFSET_W-1:0] offset_out
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [7:0]          slip_count_out,
  output logic [7:0]          loss_count_out
`endif
);

  localparam int SRCH_W = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int LOSS_W = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;
  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);

  localparam logic [SRCH_W-1:0] SRCH_LAST = SRCH_W'(SEARCH_WINDOW - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(TOKEN_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(TOKEN_RUN);

  logic [9:0]          r_prev_word;
  logic [18:0]         w_window;
  logic [9:0]          w_sym;
  logic                w_is_token;
  logic [1:0]          w_tok_ctrl;
  logic [7:0]          w_dec_data;

  align_state_t        r_state;
  align_state_t        w_state_nxt;
  logic [OFFSET_W-1:0] r_offset;
  logic [OFFSET_W-1:0] w_offset_nxt;
  logic [SRCH_W-1:0]   r_srch_cnt;
  logic [SRCH_W-1:0]   w_srch_cnt_nxt;
  logic [RUN_W-1:0]    r_run_cnt;
  logic [RUN_W-1:0]    w_run_cnt_nxt;
  logic [RUN_W-1:0]    w_run_inc;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic [LOSS_W-1:0]   w_loss_cnt_nxt;
  logic                w_qualify;
  logic                w_locked_nxt;

  logic [7:0]          r_data;
  logic [1:0]          r_ctrl;
  logic                r_ve;
  logic                r_locked;

  // Offset 9 reaches window bit 18, so the top bit of the 20-bit window is never selectable.
  assign w_window = {tmds_in[8:0], r_prev_word};

  // Barrel select of the symbol at the current bit offset.
  always_comb begin
    w_sym = w_window[9:0];
    case (r_offset)
      4'd0:    w_sym = w_window[9:0];
      4'd1:    w_sym = w_window[10:1];
      4'd2:    w_sym = w_window[11:2];
      4'd3:    w_sym = w_window[12:3];
      4'd4:    w_sym = w_window[13:4];
      4'd5:    w_sym = w_window[14:5];
      4'd6:    w_sym = w_window[15:6];
      4'd7:    w_sym = w_window[16:7];
      4'd8:    w_sym = w_window[17:8];
      4'd9:    w_sym = w_window[18:9];
      default: w_sym = w_window[9:0];
    endcase
  end

  tmds_symbol_decode u_symbol_decode (
    .i_sym      (w_sym),
    .o_is_token (w_is_token),
    .o_ctrl     (w_tok_ctrl),
    .o_data     (w_dec_data)
  );

  assign w_run_inc = (r_run_cnt == RUN_FULL) ? RUN_FULL : (r_run_cnt + RUN_W'(1));
  assign w_qualify = w_is_token && (w_run_inc == RUN_FULL);

  // Alignment FSM next state and counter updates.
  always_comb begin
    w_state_nxt    = r_state;
    w_offset_nxt   = r_offset;
    w_srch_cnt_nxt = r_srch_cnt;
    w_run_cnt_nxt  = r_run_cnt;
    w_loss_cnt_nxt = r_loss_cnt;
    case (r_state)
      SEARCH: begin
        w_run_cnt_nxt  = '0;
        w_loss_cnt_nxt = '0;
        // Slip wins over a coincident token; that token is discarded, not carried over.
        if (r_srch_cnt == SRCH_LAST) begin
          w_srch_cnt_nxt = '0;
          w_offset_nxt   = (r_offset == OFFSET_MAX) ? '0 : (r_offset + OFFSET_W'(1));
        end else if (w_is_token) begin
          w_srch_cnt_nxt = '0;
          w_run_cnt_nxt  = RUN_W'(1);
          w_state_nxt    = (RUN_LAST == '0) ? LOCKED : VERIFY;
        end else begin
          w_srch_cnt_nxt = r_srch_cnt + SRCH_W'(1);
        end
      end
      VERIFY: begin
        if (!w_is_token) begin
          w_state_nxt    = SEARCH;
          w_run_cnt_nxt  = '0;
          w_srch_cnt_nxt = '0;
        end else if (r_run_cnt == RUN_LAST) begin
          w_state_nxt    = LOCKED;
          w_run_cnt_nxt  = RUN_FULL;
          w_loss_cnt_nxt = '0;
        end else begin
          w_run_cnt_nxt  = r_run_cnt + RUN_W'(1);
        end
      end
      LOCKED: begin
        if (w_is_token) begin
          w_run_cnt_nxt = w_run_inc;
        end else begin
          w_run_cnt_nxt = '0;
        end
        if (w_qualify) begin
          w_loss_cnt_nxt = '0;
        end else if (r_loss_cnt == LOSS_LAST) begin
          w_state_nxt    = SEARCH;
          w_loss_cnt_nxt = '0;
          w_run_cnt_nxt  = '0;
          w_srch_cnt_nxt = '0;
        end else begin
          w_loss_cnt_nxt = r_loss_cnt + LOSS_W'(1);
        end
      end
      default: begin
        w_state_nxt    = SEARCH;
        w_srch_cnt_nxt = '0;
        w_run_cnt_nxt  = '0;
        w_loss_cnt_nxt = '0;
      end
    endcase
  end

  assign w_locked_nxt = (w_state_nxt == LOCKED);

  // FSM state, alignment counters and previous-word delay.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state     <= SEARCH;
      r_offset    <= '0;
      r_srch_cnt  <= '0;
      r_run_cnt   <= '0;
      r_loss_cnt  <= '0;
      r_prev_word <= 10'h000;
    end else begin
      r_state     <= w_state_nxt;
      r_offset    <= w_offset_nxt;
      r_srch_cnt  <= w_srch_cnt_nxt;
      r_run_cnt   <= w_run_cnt_nxt;
      r_loss_cnt  <= w_loss_cnt_nxt;
      r_prev_word <= tmds_in;
    end
  end

  // Decoded outputs, forced to zero whenever alignment is not held.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_locked <= 1'b0;
      r_data   <= 8'h00;
      r_ctrl   <= 2'b00;
      r_ve     <= 1'b0;
    end else begin
      r_locked <= w_locked_nxt;
      if (!w_locked_nxt) begin
        r_data <= 8'h00;
        r_ctrl <= 2'b00;
        r_ve   <= 1'b0;
      end else if (w_is_token) begin
        r_data <= 8'h00;
        r_ctrl <= w_tok_ctrl;
        r_ve   <= 1'b0;
      end else begin
        r_data <= w_dec_data;
        r_ve   <= 1'b1;
      end
    end
  end

  assign data_out    = r_data;
  assign control_out = r_ctrl;
  assign ve_out      = r_ve;
  assign locked_out  = r_locked;
  assign offset_out  = r_offset;

`ifdef TMDS_DECODER_STATS_EN
  logic       w_slip;
  logic       w_drop;
  logic [7:0] r_slip_cnt;
  logic [7:0] r_drop_cnt;

  assign w_slip = (r_state == SEARCH) && (r_srch_cnt == SRCH_LAST);
  assign w_drop = (r_state == LOCKED) && (w_state_nxt == SEARCH);

  // Saturating slip and lock-loss event counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_slip_cnt <= 8'h00;
      r_drop_cnt <= 8'h00;
    end else begin
      if (w_slip && (r_slip_cnt != 8'hFF)) begin
        r_slip_cnt <= r_slip_cnt + 8'd1;
      end
      if (w_drop && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end
  end

  assign slip_count_out = r_slip_cnt;
  assign loss_count_out = r_drop_cnt;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: DVI-style encoder model feeding a fixed-latency scoreboard.
module tb_tmds_decoder;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] tmds_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       locked_out;
  logic [3:0] offset_out;
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] slip_count_out;
  logic [7:0] loss_count_out;
`endif

  tmds_decoder #(
    .TOKEN_RUN     (8),
    .SEARCH_WINDOW (2048),
    .LOSS_WINDOW   (4096)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .tmds_in        (tmds_in),
    .data_out       (data_out),
    .control_out    (control_out),
    .ve_out         (ve_out),
    .locked_out     (locked_out),
    .offset_out     (offset_out)
`ifdef TMDS_DECODER_STATS_EN
    ,
    .slip_count_out (slip_count_out),
    .loss_count_out (loss_count_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic       chk;
    logic       lock;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       ve;
  } exp_t;

  exp_t       sb_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         rot = 0;
  int         enc_disp = 0;
  logic [9:0] prev_sym = 10'h000;

  function automatic logic [9:0] enc_ctrl(input logic [1:0] c);
    enc_disp = 0;
    case (c)
      2'b00:   return 10'b1101010100;
      2'b01:   return 10'b0010101011;
      2'b10:   return 10'b0101010100;
      default: return 10'b1010101011;
    endcase
  endfunction

  function automatic logic [9:0] enc_data(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm    = 9'h000;
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_disp = enc_disp + n0q - n1q;
      else               enc_disp = enc_disp + n1q - n0q;
    end else if ((enc_disp > 0 && n1q > n0q) || (enc_disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_disp = enc_disp + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_disp = enc_disp - (qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  function automatic exp_t e_none();
    return '0;
  endfunction

  function automatic exp_t e_unl();
    exp_t e = '0;
    e.chk = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_tok(input logic [1:0] c);
    exp_t e = '0;
    e.chk  = 1'b1;
    e.lock = 1'b1;
    e.ctrl = c;
    return e;
  endfunction

  function automatic exp_t e_dat(input logic [7:0] d, input logic [1:0] c);
    exp_t e = '0;
    e.chk  = 1'b1;
    e.lock = 1'b1;
    e.data = d;
    e.ctrl = c;
    e.ve   = 1'b1;
    return e;
  endfunction

  // Symbol k is serialised with `rot` bits of lead-in; its decode appears two negedges later.
  task automatic step(input logic [9:0] sym, input exp_t e, input string tag);
    exp_t       x;
    string      t;
    logic [19:0] pair;
    @(negedge clk_in);
    if (sb_q.size() >= 2) begin
      x = sb_q.pop_front();
      t = tag_q.pop_front();
      if (x.chk) begin
        n_checks++;
        if (locked_out !== x.lock || data_out !== x.data || control_out !== x.ctrl || ve_out !== x.ve) begin
          n_errors++;
          $display("FAIL %s: got lock=%b data=%02h ctrl=%b ve=%b, expected lock=%b data=%02h ctrl=%b ve=%b",
                   t, locked_out, data_out, control_out, ve_out, x.lock, x.data, x.ctrl, x.ve);
        end
      end
    end
    pair     = {sym, prev_sym};
    tmds_in  = pair[(10 - rot) +: 10];
    prev_sym = sym;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in   = 1'b1;
    tmds_in  = 10'h000;
    prev_sym = 10'h000;
    enc_disp = 0;
    sb_q.delete();
    tag_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic flush();
    step(enc_ctrl(2'b00), e_none(), "flush");
    step(enc_ctrl(2'b00), e_none(), "flush");
  endtask

  task automatic lock_run(input int n);
    for (int i = 1; i <= n; i++)
      step(enc_ctrl(2'b00), (i < 8) ? e_unl() : e_tok(2'b00), "lock_run");
  endtask

  task automatic test_reset();
    rst_in  = 1'b1;
    tmds_in = 10'b1101010100;
    repeat (4) @(negedge clk_in);
    n_checks++;
    if ({data_out, control_out, ve_out, locked_out, offset_out} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_state: got data=%02h ctrl=%b ve=%b lock=%b off=%0d, expected all zero",
               data_out, control_out, ve_out, locked_out, offset_out);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_aligned_lock();
    do_reset();
    rot = 0;
    for (int i = 1; i <= 16; i++)
      step(enc_ctrl(2'b00), (i < 8) ? e_unl() : e_tok(2'b00), "aligned_tokens");
    step(enc_data(8'hA5), e_dat(8'hA5, 2'b00), "aligned_a5");
    step(enc_data(8'h3C), e_dat(8'h3C, 2'b00), "aligned_3c");
    flush();
    n_checks++;
    if (offset_out !== 4'd0) begin
      n_errors++;
      $display("FAIL aligned_offset: got %0d, expected 0", offset_out);
    end
  endtask

  task automatic test_rotated_search();
    do_reset();
    rot = 7;
    for (int i = 1; i <= 7 * 2048 + 300; i++) begin
      step(enc_ctrl(2'b00), e_none(), "rot_tokens");
      if ((i % 2048) == 1024 && i < 7 * 2048) begin
        n_checks++;
        if (offset_out !== 4'(i / 2048) || locked_out !== 1'b0) begin
          n_errors++;
          $display("FAIL rot_slip_step: at cycle %0d got off=%0d lock=%b, expected off=%0d lock=0",
                   i, offset_out, locked_out, i / 2048);
        end
      end
    end
    n_checks++;
    if (offset_out !== 4'd7 || locked_out !== 1'b1) begin
      n_errors++;
      $display("FAIL rot_lock: got off=%0d lock=%b, expected off=7 lock=1", offset_out, locked_out);
    end
`ifdef TMDS_DECODER_STATS_EN
    n_checks++;
    if (slip_count_out !== 8'd7) begin
      n_errors++;
      $display("FAIL rot_slip_count: got %0d, expected 7", slip_count_out);
    end
`endif
    for (int v = 0; v < 8; v++)
      step(enc_data(8'(v * 37 + 1)), e_dat(8'(v * 37 + 1), 2'b00), "rot_data");
    flush();
    rot = 0;
  endtask

  task automatic test_short_run();
    do_reset();
    for (int i = 0; i < 5; i++) step(enc_ctrl(2'b00), e_unl(), "short_tokens");
    for (int i = 0; i < 4; i++) step(enc_data(8'(i + 16)), e_unl(), "short_data");
    flush();
    n_checks++;
    if (locked_out !== 1'b0 || offset_out !== 4'd0) begin
      n_errors++;
      $display("FAIL short_run_state: got lock=%b off=%0d, expected lock=0 off=0", locked_out, offset_out);
    end
    for (int i = 0; i < 3; i++) step(enc_data(8'(i + 64)), e_none(), "short_gap");
    lock_run(8);
    flush();
  endtask

  task automatic test_loss();
    do_reset();
    lock_run(10);
    for (int n = 1; n <= 4096; n++)
      step(enc_data(8'(n)), (n < 4096) ? e_dat(8'(n), 2'b00) : e_unl(), "loss_data");
    for (int n = 0; n < 3; n++) step(enc_data(8'(n)), e_unl(), "loss_after");
    step(enc_data(8'h00), e_none(), "loss_flush");
    step(enc_data(8'h00), e_none(), "loss_flush");
    n_checks++;
    if (offset_out !== 4'd0 || locked_out !== 1'b0) begin
      n_errors++;
      $display("FAIL loss_state: got off=%0d lock=%b, expected off=0 lock=0", offset_out, locked_out);
    end
`ifdef TMDS_DECODER_STATS_EN
    n_checks++;
    if (loss_count_out !== 8'd1 || slip_count_out !== 8'd0) begin
      n_errors++;
      $display("FAIL loss_stats: got loss=%0d slip=%0d, expected loss=1 slip=0", loss_count_out, slip_count_out);
    end
`endif
  endtask

  task automatic test_frame();
    logic       vs;
    logic [1:0] c;
    do_reset();
    lock_run(16);
    for (int line = 0; line < 4; line++) begin
      vs = (line < 2);
      for (int k = 0; k < 40; k++) begin
        c = {vs, (k >= 12 && k < 28)};
        step(enc_ctrl(c), e_tok(c), "frame_sync");
      end
      for (int v = 0; v < 256; v++)
        step(enc_data(8'(v)), e_dat(8'(v), {vs, 1'b0}), "frame_pixel");
    end
    flush();
  endtask

  task automatic test_midframe_reset();
    do_reset();
    lock_run(16);
    for (int v = 0; v < 100; v++)
      step(enc_data(8'(v + 100)), e_dat(8'(v + 100), 2'b00), "mid_pixel");
    @(negedge clk_in);
    n_checks++;
    if (locked_out !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_prelock: got lock=%b, expected 1", locked_out);
    end
    #2 rst_in = 1'b1;
    #1;
    n_checks++;
    if ({data_out, control_out, ve_out, locked_out, offset_out} !== 16'h0000) begin
      n_errors++;
      $display("FAIL mid_async_reset: got data=%02h ctrl=%b ve=%b lock=%b off=%0d, expected all zero",
               data_out, control_out, ve_out, locked_out, offset_out);
    end
    tmds_in  = 10'h000;
    prev_sym = 10'h000;
    enc_disp = 0;
    sb_q.delete();
    tag_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    lock_run(8);
    flush();
    n_checks++;
    if (offset_out !== 4'd0 || locked_out !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_relock: got off=%0d lock=%b, expected off=0 lock=1", offset_out, locked_out);
    end
  endtask

  initial begin
    rst_in  = 1'b1;
    tmds_in = 10'h000;
    test_reset();
    test_aligned_lock();
    test_rotated_search();
    test_short_run();
    test_loss();
    test_frame();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
